// File: rtl/lsu_pkg.sv
// Shared types for the load path: access-size encoding, FSM states and the
// alignment rule used when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } ld_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // The illegal size encoding is treated as misaligned so it faults the same way.
  function automatic logic is_misaligned(input ld_size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane selection and zero/sign extension of a returned memory word.
// Purely combinational; the caller registers the result.
module load_align
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    addr_lo,
  input  ld_size_e      size,
  input  logic          sign_ext,
  output logic [DW-1:0] data
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Only the low 32 bits carry addressable lanes; wider words just pass through.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lane[gi] = rdata[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = rdata[16*gi +: 16];
  end

  assign byte_sel = byte_lane[addr_lo];
  assign half_sel = half_lane[addr_lo[1]];

  always_comb begin
    data = '0;
    case (size)
      SZ_BYTE: data = {{(DW-8){sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data = {{(DW-16){sign_ext & half_sel[15]}}, half_sel};
      SZ_WORD: data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: accepts a core load, issues one word read,
// aligns/extends the returned data and holds the writeback until taken.
module load_unit
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [1:0]    ld_size,
  input  logic          ld_signed,
  input  logic [RW-1:0] ld_rd,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err,
  output logic          wb_valid,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_rd,
  output logic          wb_err,
  input  logic          wb_ready
);

  lsu_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  ld_size_e      size_q, size_d;
  logic          sign_q, sign_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  ld_size_e      req_size;
  logic [DW-1:0] aligned_data;

  assign req_size = ld_size_e'(ld_size);

  load_align #(
    .DW (DW)
  ) u_align (
    .rdata    (mem_rdata),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sign_q),
    .data     (aligned_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sign_d   = sign_q;
    rd_d     = rd_q;
    data_d   = data_q;
    err_d    = err_q;

    ld_ready = 1'b0;
    mem_req  = 1'b0;
    wb_valid = 1'b0;

    case (state_q)
      IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          addr_d = ld_addr;
          size_d = req_size;
          sign_d = ld_signed;
          rd_d   = ld_rd;
          data_d = '0;
          // Faulting requests skip the bus entirely and report straight away.
          if (is_misaligned(req_size, ld_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          err_d   = mem_err;
          data_d  = mem_err ? '0 : aligned_data;
          state_d = RESP;
        end
      end
      RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = {addr_q[AW-1:2], 2'b00};
  assign wb_data  = data_q;
  assign wb_rd    = rd_q;
  assign wb_err   = err_q & wb_valid;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: vector table of single loads plus stall and
// reset-in-flight sequences.
module tb_load_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk;
  logic          reset;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_size;
  logic          ld_signed;
  logic [RW-1:0] ld_rd;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;
  logic          wb_err;
  logic          wb_ready;

  int n_tests = 0;
  int n_fail  = 0;

  load_unit #(.AW(AW), .DW(DW), .RW(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_size    (ld_size),
    .ld_signed  (ld_signed),
    .ld_rd      (ld_rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_err     (wb_err),
    .wb_ready   (wb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [3:0]  rd;
    logic [31:0] rdata;
    logic        err;
    logic        fault;      // expected to fault without touching memory
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " ld_ready"}, 32'(ld_ready), 32'd1);
    ld_valid  = 1'b1;
    ld_addr   = v.addr;
    ld_size   = v.size;
    ld_signed = v.sgn;
    ld_rd     = v.rd;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    chk({v.name, " ld_ready_busy"}, 32'(ld_ready), 32'd0);
    if (v.fault) begin
      chk({v.name, " no_mem_req"}, 32'(mem_req), 32'd0);
    end else begin
      chk({v.name, " mem_req"}, 32'(mem_req), 32'd1);
      chk({v.name, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      mem_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_gnt = 1'b0;
      chk({v.name, " wait_no_req"}, 32'(mem_req), 32'd0);
      chk({v.name, " wait_no_wb"}, 32'(wb_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      mem_err    = v.err;
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
    end
    chk({v.name, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({v.name, " wb_data"}, wb_data, v.exp_data);
    chk({v.name, " wb_err"}, 32'(wb_err), 32'(v.exp_err));
    chk({v.name, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
    $display("[TB] %s addr=%h size=%0d signed=%0d -> data=%h err=%0d", v.name, v.addr, v.size, v.sgn, wb_data, wb_err);
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_ready = 1'b0;
    chk({v.name, " back_idle"}, 32'(ld_ready), 32'd1);
    chk({v.name, " wb_done"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"ldrb_1003",   32'h0000_1003, 2'b00, 1'b0, 4'd5,  32'h80AB_CD12, 1'b0, 1'b0, 32'h0000_0080, 1'b0};
    vecs[1]  = '{"ldrsh_2002",  32'h0000_2002, 2'b01, 1'b1, 4'd7,  32'h9ABC_1234, 1'b0, 1'b0, 32'hFFFF_9ABC, 1'b0};
    vecs[2]  = '{"ldw_mis3001", 32'h0000_3001, 2'b10, 1'b0, 4'd3,  32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3]  = '{"ldw_err",     32'h0000_4000, 2'b10, 1'b0, 4'd9,  32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{"ldrsb_1001",  32'h0000_1001, 2'b00, 1'b1, 4'd1,  32'h80AB_CD12, 1'b0, 1'b0, 32'hFFFF_FFCD, 1'b0};
    vecs[5]  = '{"ldrsb_1000",  32'h0000_1000, 2'b00, 1'b1, 4'd2,  32'h80AB_CD12, 1'b0, 1'b0, 32'h0000_0012, 1'b0};
    vecs[6]  = '{"ldrh_2000",   32'h0000_2000, 2'b01, 1'b0, 4'd4,  32'h9ABC_8234, 1'b0, 1'b0, 32'h0000_8234, 1'b0};
    vecs[7]  = '{"ldrsh_2000",  32'h0000_2000, 2'b01, 1'b1, 4'd6,  32'h9ABC_8234, 1'b0, 1'b0, 32'hFFFF_8234, 1'b0};
    vecs[8]  = '{"ldw_5004",    32'h0000_5004, 2'b10, 1'b1, 4'd8,  32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[9]  = '{"ldh_mis2001", 32'h0000_2001, 2'b01, 1'b0, 4'd10, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[10] = '{"ld_size11",   32'h0000_6000, 2'b11, 1'b0, 4'd11, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[11] = '{"ldrsb_1002",  32'h0000_1002, 2'b00, 1'b1, 4'd12, 32'h807F_CD12, 1'b0, 1'b0, 32'h0000_007F, 1'b0};
    vecs[12] = '{"ldw_mis3002", 32'hFFFF_3002, 2'b10, 1'b0, 4'd13, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1};

    reset      = 1'b0;
    ld_valid   = 1'b0;
    ld_addr    = '0;
    ld_size    = 2'b00;
    ld_signed  = 1'b0;
    ld_rd      = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    wb_ready   = 1'b0;

    #1;
    chk("reset ld_ready", 32'(ld_ready), 32'd1);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset wb_err", 32'(wb_err), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset wb_rd", 32'(wb_rd), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // Stalled grant and stalled writeback; extra requests and stray rvalid must be ignored.
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h0000_7008; ld_size = 2'b10; ld_signed = 1'b0; ld_rd = 4'd9;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ld_addr    = 32'h0000_9000 + 32'(c);
      mem_rvalid = (c == 2);
      mem_rdata  = 32'h1111_1111;
      chk("stall mem_req", 32'(mem_req), 32'd1);
      chk("stall mem_addr", mem_addr, 32'h0000_7008);
      chk("stall ld_ready", 32'(ld_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    ld_valid = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1;
    chk("stall mem_req_gnt", 32'(mem_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
      chk("hold wb_valid", 32'(wb_valid), 32'd1);
      chk("hold wb_data", wb_data, 32'hCAFE_F00D);
      chk("hold wb_rd", 32'(wb_rd), 32'd9);
      chk("hold wb_err", 32'(wb_err), 32'd0);
      chk("hold ld_ready", 32'(ld_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; wb_ready = 1'b1;
    $display("[TB] stall_load addr=00007008 -> data=%h err=%0d", wb_data, wb_err);
    @(posedge clk);
    @(negedge clk);
    wb_ready = 1'b0;
    chk("stall single_wb", 32'(wb_valid), 32'd0);
    chk("stall idle", 32'(ld_ready), 32'd1);
    @(negedge clk);
    chk("stall no_second_wb", 32'(wb_valid), 32'd0);

    // Reset asserted while waiting for read data, then a late rvalid arrives.
    ld_valid = 1'b1; ld_addr = 32'h0000_8000; ld_size = 2'b10; ld_rd = 4'd14;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst wait_state", 32'(mem_req), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst async ld_ready", 32'(ld_ready), 32'd1);
    chk("rst async mem_addr", mem_addr, 32'd0);
    chk("rst async wb_rd", 32'(wb_rd), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    $display("[TB] reset_in_wait -> wb_valid=%0d ld_ready=%0d", wb_valid, ld_ready);
    chk("rst late_rvalid wb_valid", 32'(wb_valid), 32'd0);
    chk("rst late_rvalid ld_ready", 32'(ld_ready), 32'd1);
    chk("rst late_rvalid mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("rst still_idle", 32'(wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
